simd_dotp_acc: RTL and testbench
================================

SIMD_DOTP_ACC -- requirements
Module: simd_dotp_acc

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and result width.
REQ-002 SHALL have parameter ELEM_W, default 8, meaning lane element width; legal values are 8 and 16.
REQ-003 SHALL have parameter ID_W, default 4, meaning width of the instruction tag passed through with each operation.
REQ-004 SHALL derive localparam NUM_LANES = XLEN/ELEM_W.
REQ-005 SHALL have the following ports, clock and reset first:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- in_valid_i  in  1  operation offered.
- in_ready_o  out  1  operation accepted when in_valid_i is also high.
- operand_a_i  in  XLEN  packed lane vector A.
- operand_b_i  in  XLEN  packed lane vector B.
- operand_c_i  in  XLEN  scalar addend.
- id_i  in  ID_W  operation tag.
- signed_i  in  1  1 = lanes and addend are two's complement; 0 = unsigned.
- acc_i  in  1  1 = add operand_c_i; 0 = addend is zero.
- sat_i  in  1  1 = saturate the result; 0 = wrap modulo 2^XLEN.
- result_valid_o  out  1  result available.
- result_ready_i  in  1  result consumed when result_valid_o is also high.
- result_o  out  XLEN  dot-product result.
- id_o  out  ID_W  tag of the result.

Function
REQ-006 SHALL compute result = sum over lanes i of A[i]*B[i], plus C when acc_i=1, where lane i occupies bits [i*ELEM_W +: ELEM_W].
REQ-007 SHALL sign-extend or zero-extend each lane according to signed_i, giving products of 2*ELEM_W bits.
REQ-008 SHALL sum products and addend in a width of XLEN+2 bits, so that no intermediate overflow is possible.
REQ-009 SHALL, when sat_i=1, clamp the sum as follows:
- signed mode: to the range [-2^(XLEN-1), 2^(XLEN-1)-1].
- unsigned mode: to the range [0, 2^XLEN-1].
REQ-010 SHALL, when sat_i=0, output the low XLEN bits of the sum.
REQ-011 SHALL be a two-stage pipeline:
- S1 registers the per-lane products together with id, signed, acc, sat and C.
- S2 registers result_o and id_o.
- Latency is 2 cycles from acceptance to result_valid_o under no backpressure.
REQ-012 SHALL sustain one accepted operation per cycle while result_ready_i=1.
REQ-013 SHALL hold S2 stable (result_o, id_o, result_valid_o) while result_valid_o=1 and result_ready_i=0.
REQ-014 SHALL advance S1 into S2 when S2 is empty or is draining in the same cycle.
REQ-015 SHALL drive in_ready_o = (S1 empty) OR (S1 advancing this cycle), combinationally from result_ready_i, with no combinational path from in_valid_i.
REQ-016 SHALL buffer at most two operations in flight, deliver results in acceptance order, and never drop or duplicate a result.
REQ-017 SHALL allow in_valid_i and result_ready_i to be high simultaneously with a full pipeline, accepting one operation and retiring one in the same cycle.
REQ-018 SHALL ignore operand_c_i when acc_i=0, whatever its value.

Reset
REQ-019 SHALL, on rst_i=1 at a clock edge, clear both stage valid bits and set result_valid_o=0, result_o=0 and id_o=0.
REQ-020 SHALL discard in-flight operations on reset and produce no result for them after reset is released.
REQ-021 SHALL hold in_ready_o=1 in the first cycle after reset is released.

Structure
REQ-022 SHALL place the ELEM_W legality check, the mode-flag struct (signed, acc, sat) and the saturation bounds function in a shared package named simd_dotp_pkg.
REQ-023 SHALL implement the per-lane multiplier as sub-module dotp_lane_mul, instantiated NUM_LANES times via generate.

Verification
REQ-024 SHALL pass an unsigned, ELEM_W=8 test: A=0x01020304, B=0x05060708, acc=0 -> result 0x00000046 two cycles after acceptance.
REQ-025 SHALL pass a signed test: A=0xFFFFFFFF, B=0x01010101, acc=0 -> result 0xFFFFFFFC.
REQ-026 SHALL pass an unsigned accumulate test: A=B=0xFFFFFFFF, C=0xFFFFFFFF, acc=1 -> result 0xFFFFFFFF with sat=1, and 0x0003F803 with sat=0.
REQ-027 SHALL pass a signed accumulate test: A=B=0x80808080, C=0x7FFFFFFF, acc=1 -> result 0x7FFFFFFF with sat=1, and 0x8000FFFF with sat=0.
REQ-028 SHALL pass a backpressure test: 5 back-to-back operations with ids 0-4 while result_ready_i is held low for 4 cycles -> in_ready_o drops after 2 acceptances, and results emerge in id order 0-4 with none lost.
REQ-029 SHALL pass a reset and width test:
- rst_i asserted with 2 operations in flight -> no result_valid_o afterwards.
- Then ELEM_W=16 with A=0x00030004, B=0x00050006 -> result 0x00000027.

Source files
------------

// File: rtl/simd_dotp_pkg.sv
// Shared types and helpers for the SIMD dot-product accumulate unit.
package simd_dotp_pkg;

  // Wide enough for saturation bounds of any XLEN up to 64 plus the two guard bits.
  localparam int MAXW = 66;

  typedef struct packed {
    logic sgn;
    logic acc;
    logic sat;
  } dotp_mode_t;

  function automatic bit elem_w_legal(input int w);
    return (w == 8) || (w == 16);
  endfunction

  function automatic logic [MAXW-1:0] sat_hi(input int xlen, input logic sgn);
    logic [MAXW-1:0] one;
    one = MAXW'(1);
    return sgn ? (one << (xlen - 1)) - one : (one << xlen) - one;
  endfunction

  // Two's-complement -2^(xlen-1) for signed, zero for unsigned.
  function automatic logic [MAXW-1:0] sat_lo(input int xlen, input logic sgn);
    logic [MAXW-1:0] one;
    one = MAXW'(1);
    return sgn ? ~((one << (xlen - 1)) - one) : '0;
  endfunction

endpackage

// File: rtl/simd_dotp_acc_lane_mul.sv
// One SIMD lane: extends both elements per the signed flag and multiplies.
module dotp_lane_mul #(
  parameter int ELEM_W = 8
) (
  input  logic [ELEM_W-1:0]   a_i,
  input  logic [ELEM_W-1:0]   b_i,
  input  logic                signed_i,
  output logic [2*ELEM_W-1:0] prod_o
);

  logic [2*ELEM_W-1:0] a_x, b_x;

  // Low 2*ELEM_W bits of the extended product are exact for both signednesses.
  assign a_x    = {{ELEM_W{signed_i & a_i[ELEM_W-1]}}, a_i};
  assign b_x    = {{ELEM_W{signed_i & b_i[ELEM_W-1]}}, b_i};
  assign prod_o = a_x * b_x;

endmodule

// File: rtl/simd_dotp_acc.sv
// Two-stage SIMD dot product with optional addend and saturation, valid/ready on both sides.
module simd_dotp_acc
  import simd_dotp_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ELEM_W = 8,
  parameter int ID_W   = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic [XLEN-1:0] operand_c_i,
  input  logic [ID_W-1:0] id_i,
  input  logic            signed_i,
  input  logic            acc_i,
  input  logic            sat_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [ID_W-1:0] id_o
);

  localparam int NUM_LANES = XLEN / ELEM_W;
  localparam int PW        = 2 * ELEM_W;
  localparam int SW        = XLEN + 2;

  if (!elem_w_legal(ELEM_W)) begin : g_bad_elem_w
    $error("simd_dotp_acc: ELEM_W must be 8 or 16");
  end
  if (NUM_LANES < 2 || XLEN > 64) begin : g_bad_xlen
    $error("simd_dotp_acc: XLEN must hold at least two lanes and be at most 64");
  end

  logic                          s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s1_adv;
  logic [NUM_LANES-1:0][PW-1:0]  prod_d, prod_q;
  logic [ID_W-1:0]               s1_id_q, id_q;
  logic [XLEN-1:0]               c_q, result_q, result_d;
  dotp_mode_t                    mode_d, mode_q;
  logic [SW-1:0]                 sum, hi, lo;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dotp_lane_mul #(.ELEM_W(ELEM_W)) u_mul (
      .a_i      (operand_a_i[g*ELEM_W +: ELEM_W]),
      .b_i      (operand_b_i[g*ELEM_W +: ELEM_W]),
      .signed_i (signed_i),
      .prod_o   (prod_d[g])
    );
  end

  // S1 moves on when S2 is empty or is being drained this cycle.
  assign s1_adv     = s1_vld_q & (~s2_vld_q | result_ready_i);
  assign in_ready_o = ~s1_vld_q | s1_adv;
  assign s1_vld_d   = in_ready_o ? in_valid_i : s1_vld_q;
  assign s2_vld_d   = s1_adv | (s2_vld_q & ~result_ready_i);
  assign mode_d     = '{sgn: signed_i, acc: acc_i, sat: sat_i};

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_LANES; i++)
      sum = sum + (mode_q.sgn ? {{(SW-PW){prod_q[i][PW-1]}}, prod_q[i]}
                              : {{(SW-PW){1'b0}}, prod_q[i]});
    if (mode_q.acc)
      sum = sum + (mode_q.sgn ? {{2{c_q[XLEN-1]}}, c_q} : {2'b00, c_q});
  end

  always_comb begin
    hi       = SW'(sat_hi(XLEN, mode_q.sgn));
    lo       = SW'(sat_lo(XLEN, mode_q.sgn));
    result_d = sum[XLEN-1:0];
    if (mode_q.sat) begin
      if (mode_q.sgn) begin
        if ($signed(sum) > $signed(hi))      result_d = hi[XLEN-1:0];
        else if ($signed(sum) < $signed(lo)) result_d = lo[XLEN-1:0];
      end else if (sum > hi) begin
        result_d = hi[XLEN-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      result_q <= '0;
      id_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      if (s1_adv) begin
        result_q <= result_d;
        id_q     <= s1_id_q;
      end
    end
  end

  // Datapath payload needs no reset; its valid bit guards it.
  always_ff @(posedge clk_i) begin
    if (in_valid_i && in_ready_o) begin
      prod_q  <= prod_d;
      s1_id_q <= id_i;
      mode_q  <= mode_d;
      c_q     <= operand_c_i;
    end
  end

  assign result_valid_o = s2_vld_q;
  assign result_o       = result_q;
  assign id_o           = id_q;

endmodule

// File: tb/tb_simd_dotp_acc.sv
// Randomized scoreboard bench for simd_dotp_acc (ELEM_W=8 and ELEM_W=16 instances).
module tb_simd_dotp_acc;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  id;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv8 = 0, rdy8, sg8 = 0, ac8 = 0, st8 = 0, rr8 = 1, rv8;
  logic [31:0] a8 = 0, b8 = 0, c8 = 0, r8;
  logic [3:0]  id8 = 0, ido8;
  logic        iv16 = 0, rdy16, sg16 = 0, ac16 = 0, st16 = 0, rr16 = 1, rv16;
  logic [31:0] a16 = 0, b16 = 0, c16 = 0, r16;
  logic [3:0]  id16 = 0, ido16;

  simd_dotp_acc #(.XLEN(32), .ELEM_W(8), .ID_W(4)) dut8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv8), .in_ready_o(rdy8),
    .operand_a_i(a8), .operand_b_i(b8), .operand_c_i(c8), .id_i(id8),
    .signed_i(sg8), .acc_i(ac8), .sat_i(st8), .result_valid_o(rv8),
    .result_ready_i(rr8), .result_o(r8), .id_o(ido8));

  simd_dotp_acc #(.XLEN(32), .ELEM_W(16), .ID_W(4)) dut16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv16), .in_ready_o(rdy16),
    .operand_a_i(a16), .operand_b_i(b16), .operand_c_i(c16), .id_i(id16),
    .signed_i(sg16), .acc_i(ac16), .sat_i(st16), .result_valid_o(rv16),
    .result_ready_i(rr16), .result_o(r16), .id_o(ido16));

  exp_t sb8[$], sb16[$];
  int checks = 0, errors = 0, cyc = 0;
  bit rand_rdy = 0;
  logic [31:0] spec_v [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Dot product from the arithmetic definition, in 64-bit integers.
  function automatic logic [31:0] model(input int ew, input logic [31:0] a, b, c,
                                        input bit s, ac, st);
    longint sum = 0, x, y, m;
    m = (64'sd1 <<< ew) - 1;
    for (int i = 0; i < 32 / ew; i++) begin
      x = longint'(a >> (i * ew)) & m;
      y = longint'(b >> (i * ew)) & m;
      if (s && x >= (64'sd1 <<< (ew - 1))) x -= (64'sd1 <<< ew);
      if (s && y >= (64'sd1 <<< (ew - 1))) y -= (64'sd1 <<< ew);
      sum += x * y;
    end
    if (ac) sum += s ? longint'($signed(c)) : longint'(c);
    if (st) begin
      if (s) begin
        if (sum > 64'sd2147483647)  sum = 64'sd2147483647;
        if (sum < -64'sd2147483648) sum = -64'sd2147483648;
      end else if (sum > 64'sd4294967295) sum = 64'sd4294967295;
    end
    return sum[31:0];
  endfunction

  function automatic logic [31:0] rnd_op();
    if ($urandom_range(3) == 0) return spec_v[$urandom_range(5)];
    return $urandom();
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) rr8 = ($urandom_range(3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input bit w16, input logic [31:0] a, b, c, input logic [3:0] id,
                      input bit s, ac, st, input bit lat, input bit ovr, input logic [31:0] ev);
    bit took = 0;
    exp_t e;
    e.res = ovr ? ev : model(w16 ? 16 : 8, a, b, c, s, ac, st);
    e.id  = id;
    e.lat = lat;
    if (w16) begin iv16 = 1; a16 = a; b16 = b; c16 = c; id16 = id; sg16 = s; ac16 = ac; st16 = st; end
    else     begin iv8  = 1; a8  = a; b8  = b; c8  = c; id8  = id; sg8  = s; ac8  = ac; st8  = st; end
    for (int n = 0; n < 50 && !took; n++) begin
      @(negedge clk);
      if (w16 ? rdy16 : rdy8) begin
        e.cyc = cyc;
        if (w16) sb16.push_back(e); else sb8.push_back(e);
        took = 1;
      end
      tick();
    end
    iv8 = 0; iv16 = 0;
    if (!took) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    rand_rdy = 0; rr8 = 1;
    for (int n = 0; n < 100 && (sb8.size() != 0 || sb16.size() != 0); n++) tick();
    check("drain8", sb8.size(), 0);
    check("drain16", sb16.size(), 0);
  endtask

  // Monitor for the ELEM_W=8 instance, including hold-under-stall checks.
  bit          stall8 = 0;
  logic [36:0] held8;
  always @(negedge clk) begin
    exp_t e;
    if (rst) stall8 = 0;
    else begin
      if (stall8) check("hold_stable", {rv8, r8, ido8}, held8);
      stall8 = 0;
      if (rv8) begin
        if (!rr8) begin
          stall8 = 1; held8 = {rv8, r8, ido8};
        end else if (sb8.size() == 0) check("unexpected_result8", {ido8, r8}, 0);
        else begin
          e = sb8.pop_front();
          check("result8", r8, e.res);
          check("id8", ido8, e.id);
          if (e.lat) check("latency8", cyc - e.cyc, 2);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rv16 && rr16) begin
      if (sb16.size() == 0) check("unexpected_result16", {ido16, r16}, 0);
      else begin
        e = sb16.pop_front();
        check("result16", r16, e.res);
        check("id16", ido16, e.id);
        if (e.lat) check("latency16", cyc - e.cyc, 2);
      end
    end
  end

  initial begin
    int k, nacc;
    bit took;
    exp_t e;
    spec_v[0] = 32'h0;        spec_v[1] = 32'hFFFFFFFF; spec_v[2] = 32'h80808080;
    spec_v[3] = 32'h7F7F7F7F; spec_v[4] = 32'h80000000; spec_v[5] = 32'h7FFFFFFF;

    idle(3);
    rst = 0;
    @(negedge clk);
    check("rst_valid8", rv8, 0);  check("rst_result8", r8, 0);  check("rst_id8", ido8, 0);
    check("rst_ready8", rdy8, 1); check("rst_valid16", rv16, 0); check("rst_ready16", rdy16, 1);
    tick();

    // Directed vectors with known answers, pipeline idle so latency is exact.
    send(0, 32'h01020304, 32'h05060708, 32'hDEADBEEF, 4'd1, 0, 0, 0, 1, 1, 32'h00000046); idle(3);
    send(0, 32'hFFFFFFFF, 32'h01010101, 32'h12345678, 4'd2, 1, 0, 0, 1, 1, 32'hFFFFFFFC); idle(3);
    send(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 0, 1, 1, 1, 1, 32'hFFFFFFFF); idle(3);
    send(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 0, 1, 0, 1, 1, 32'h0003F803); idle(3);
    send(0, 32'h80808080, 32'h80808080, 32'h7FFFFFFF, 4'd5, 1, 1, 1, 1, 1, 32'h7FFFFFFF); idle(3);
    send(0, 32'h80808080, 32'h80808080, 32'h7FFFFFFF, 4'd6, 1, 1, 0, 1, 1, 32'h8000FFFF); idle(3);

    // Backpressure: ready low for 4 cycles while five ops are offered back to back.
    k = 0; nacc = 0;
    while (nacc < 5 && k < 60) begin
      iv8 = 1; id8 = 4'(nacc); a8 = $urandom(); b8 = $urandom(); c8 = $urandom();
      sg8 = 1'($urandom_range(1)); ac8 = 1; st8 = 0; rr8 = (k >= 4);
      @(negedge clk);
      if (k == 2) begin check("bp_in_ready", rdy8, 0); check("bp_accepted", nacc, 2); end
      took = rdy8;
      if (took) begin
        e.res = model(8, a8, b8, c8, sg8, ac8, st8); e.id = id8; e.cyc = cyc; e.lat = 0;
        sb8.push_back(e);
      end
      @(posedge clk); #1;
      if (took) nacc++;
      k++;
    end
    iv8 = 0;
    check("bp_all_accepted", nacc, 5);
    drain();

    // Random traffic with random backpressure.
    rand_rdy = 1;
    for (int n = 0; n < 300; n++) begin
      send(0, rnd_op(), rnd_op(), rnd_op(), 4'(n), 1'($urandom_range(1)),
           1'($urandom_range(1)), 1'($urandom_range(1)), 0, 0, 0);
      if ($urandom_range(7) == 0) idle(1);
    end
    drain();

    // Reset with two operations in flight.
    rr8 = 0;
    send(0, 32'h01010101, 32'h01010101, 0, 4'd7, 0, 0, 0, 0, 0, 0);
    send(0, 32'h02020202, 32'h01010101, 0, 4'd8, 0, 0, 0, 0, 0, 0);
    rst = 1; sb8.delete();
    idle(2);
    rst = 0; rr8 = 1;
    @(negedge clk);
    check("post_rst_ready", rdy8, 1);
    check("post_rst_state", {rv8, r8, ido8}, 0);
    for (int n = 0; n < 6; n++) begin
      tick(); @(negedge clk);
      check("post_rst_no_valid", rv8, 0);
    end
    tick();

    // ELEM_W=16 instance.
    send(1, 32'h00030004, 32'h00050006, 32'hFFFF0000, 4'd9, 0, 0, 0, 1, 1, 32'h00000027); idle(3);
    for (int n = 0; n < 40; n++)
      send(1, rnd_op(), rnd_op(), rnd_op(), 4'(n), 1'($urandom_range(1)),
           1'($urandom_range(1)), 1'($urandom_range(1)), 0, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
